memory_arbiter: RTL and testbench

- Shares the single RAM port between the instruction-fetch and data-access request streams from the pipelined datapath's cache interface.
- Grants one requester at a time and holds the grant until the RAM completes the access.
- Returns load data and per-requester wait signals.
- Default policy is data-priority, with a starvation guard so that instruction fetch always makes progress.

---
 rtl/memory_arbiter_if.sv | 30 +++
 rtl/memory_arbiter.sv | 101 ++++++++++
 tb/tb_memory_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: request and RAM bus bundle shared by memory_arbiter and its environment
//   requester side : iREN/iaddr, dREN/dWEN/daddr/dstore in; iwait/dwait/iload/dload out
//   RAM side       : ramREN/ramWEN/ramaddr/ramstore out; ramload/ram_ready in
//   slave modport  = arbiter view, master modport = environment view
interface memory_arbiter_if #(parameter int WORD_W = 32);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              iwait;
  logic              dwait;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic              ram_ready;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between instruction-fetch and data-access requesters
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : memory_arbiter_if.slave (requests, waits, load data, RAM strobes/address/data)
//   Default policy: data priority with a starvation guard (STARVE_MAX consecutive contested
//   data wins force an instruction grant). Define MEMORY_ARBITER_RR_EN for strict
//   alternation between contending requesters instead.
module memory_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic              CLK,
  input logic              nRST,
  memory_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGRANT = 2'd1;
  localparam logic [1:0] DGRANT = 2'd2;
  logic [1:0] state_q, state_d;
  logic       d_pend, i_pend, pick_d;
`ifdef MEMORY_ARBITER_RR_EN
  localparam logic DATA  = 1'b0;
  localparam logic INSTR = 1'b1;
  logic last_grant_q, last_grant_d;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt_q, starve_cnt_d;
`endif
  // Load data is a pure pass-through of the granted access; kept out of the
  // main block so the RAM read path never looks like a loop through ramaddr.
  assign bus.dload = (state_q == DGRANT) ? bus.ramload : '0;
  assign bus.iload = (state_q == IGRANT) ? bus.ramload : '0;
  always_comb begin
    d_pend = bus.dREN | bus.dWEN;
    i_pend = bus.iREN;
`ifdef MEMORY_ARBITER_RR_EN
    pick_d       = last_grant_q != DATA;
    last_grant_d = last_grant_q;
`else
    pick_d       = starve_cnt_q < STARVE_LIM;
    starve_cnt_d = starve_cnt_q;
`endif
    state_d      = state_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = i_pend;
    bus.dwait    = d_pend;
    if (state_q == IDLE) begin
      state_d = (d_pend && (!i_pend || pick_d)) ? DGRANT : i_pend ? IGRANT : IDLE;
    end else if (state_q == DGRANT) begin
      // A simultaneous read+write is treated as a write; a dropped request
      // leaves both strobes low and falls back to IDLE without completing.
      bus.ramaddr  = bus.daddr;
      bus.ramstore = bus.dstore;
      bus.ramWEN   = bus.dWEN;
      bus.ramREN   = bus.dREN & ~bus.dWEN;
      bus.dwait    = d_pend & ~bus.ram_ready;
      state_d      = (d_pend && !bus.ram_ready) ? DGRANT : IDLE;
      if (d_pend && bus.ram_ready) begin
`ifdef MEMORY_ARBITER_RR_EN
        last_grant_d = DATA;
`else
        starve_cnt_d = !i_pend ? 4'd0 : (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
`endif
      end
    end else if (state_q == IGRANT) begin
      bus.ramaddr = bus.iaddr;
      bus.ramREN  = i_pend;
      bus.iwait   = i_pend & ~bus.ram_ready;
      state_d     = (i_pend && !bus.ram_ready) ? IGRANT : IDLE;
      if (i_pend && bus.ram_ready) begin
`ifdef MEMORY_ARBITER_RR_EN
        last_grant_d = INSTR;
`else
        starve_cnt_d = 4'd0;
`endif
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
`ifdef MEMORY_ARBITER_RR_EN
      last_grant_q <= DATA;
`else
      starve_cnt_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEMORY_ARBITER_RR_EN
      last_grant_q <= last_grant_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: table-driven and scoreboarded self-checking bench for memory_arbiter
module tb_memory_arbiter;
  localparam int W = 32;
  localparam logic [W-1:0] K = 32'hA5A5_0000;
  typedef struct {
    logic         is_d;
    logic [W-1:0] addr;
    logic [W-1:0] store;
    logic         ren;
    logic         wen;
    logic [W-1:0] load;
  } sb_t;
  typedef struct {
    logic         i;
    logic         dr;
    logic         dw;
    logic [W-1:0] addr;
    logic [W-1:0] store;
    logic         exp_ren;
    logic         exp_wen;
  } vec_t;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  sb_t  sb_q[$];
  sb_t  mon_e;
  logic mon_i, mon_d;
  vec_t vt[6];
  always #5 CLK = ~CLK;
  memory_arbiter_if #(.WORD_W(W)) bus ();
  memory_arbiter #(.WORD_W(W), .STARVE_MAX(4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  // RAM model: read data is a fixed function of the presented address
  assign bus.ramload = bus.ramaddr ^ K;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic sb_t mk(input logic is_d, input logic [W-1:0] a, input logic [W-1:0] s,
                             input logic ren, input logic wen);
    mk = '{is_d, a, s, ren, wen, a ^ K};
  endfunction
  task automatic wait_done(input int target, input int limit);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      @(negedge CLK); #1;
      n++;
    end
    check("completion_timeout", {31'b0, done_cnt >= target}, 32'd1);
  endtask
  task automatic clear_req();
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask
  always @(negedge CLK) begin
    if (nRST) begin
      mon_i = bus.iREN && !bus.iwait;
      mon_d = (bus.dREN || bus.dWEN) && !bus.dwait;
      if (mon_i || mon_d) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got completion i=%0b d=%0b expected none", mon_i, mon_d);
        end else begin
          mon_e = sb_q.pop_front();
          check("grant_src", {30'b0, mon_i, mon_d}, {30'b0, !mon_e.is_d, mon_e.is_d});
          check("ramaddr", bus.ramaddr, mon_e.addr);
          check("ramREN", {31'b0, bus.ramREN}, {31'b0, mon_e.ren});
          check("ramWEN", {31'b0, bus.ramWEN}, {31'b0, mon_e.wen});
          if (mon_e.wen) check("ramstore", bus.ramstore, mon_e.store);
          else check("load", mon_e.is_d ? bus.dload : bus.iload, mon_e.load);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end
  initial begin
    int base, lat;
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_1234, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 1'b0};
    // reset state with requests pending
    bus.ram_ready = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dREN = 1'b0; bus.dWEN = 1'b1; bus.daddr = 32'h880; bus.dstore = 32'h77;
    @(negedge CLK); #1;
    check("rst_ramREN", {31'b0, bus.ramREN}, 32'd0);
    check("rst_ramWEN", {31'b0, bus.ramWEN}, 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_ramstore", bus.ramstore, 32'd0);
    check("rst_iload", bus.iload, 32'd0);
    check("rst_dload", bus.dload, 32'd0);
    check("rst_iwait", {31'b0, bus.iwait}, 32'd1);
    check("rst_dwait", {31'b0, bus.dwait}, 32'd1);
    nRST = 1'b1;
    @(posedge CLK); #1;
    check("dgrant_wen", {31'b0, bus.ramWEN}, 32'd1);
    check("dgrant_addr", bus.ramaddr, 32'h880);
    check("dgrant_store", bus.ramstore, 32'h77);
    #2 nRST = 1'b0;
    #1;
    check("async_rst_wen", {31'b0, bus.ramWEN}, 32'd0);
    check("async_rst_addr", bus.ramaddr, 32'd0);
    @(negedge CLK); #1;
    nRST = 1'b1;
    #1;
    check("post_rst_dwait", {31'b0, bus.dwait}, 32'd1);
    check("post_rst_wen", {31'b0, bus.ramWEN}, 32'd0);
    @(posedge CLK); #1;
    check("regrant_wen", {31'b0, bus.ramWEN}, 32'd1);
    clear_req();
    @(posedge CLK); #1;
    bus.ram_ready = 1'b1;
    // single transactions from the vector table
    for (int v = 0; v < 6; v++) begin
      @(posedge CLK); #1;
      bus.iREN = vt[v].i; bus.dREN = vt[v].dr; bus.dWEN = vt[v].dw;
      bus.iaddr = vt[v].i ? vt[v].addr : 32'hBAD4;
      bus.daddr = vt[v].i ? 32'hBAD0 : vt[v].addr;
      bus.dstore = vt[v].store;
      sb_q.push_back(mk(!vt[v].i, vt[v].addr, vt[v].store, vt[v].exp_ren, vt[v].exp_wen));
      base = done_cnt;
      lat = 0;
      while (done_cnt == base && lat < 10) begin
        @(negedge CLK); #1;
        lat++;
        if (lat == 1) check("idle_strobes", {30'b0, bus.ramREN, bus.ramWEN}, 32'd0);
      end
      check("latency", lat, 32'd2);
      @(posedge CLK); #1;
      clear_req();
    end
    // wait states: ready low for three granted cycles
    @(posedge CLK); #1;
    bus.dREN = 1'b1; bus.daddr = 32'h700; bus.ram_ready = 1'b0;
    sb_q.push_back(mk(1'b1, 32'h700, 32'h0, 1'b1, 1'b0));
    @(posedge CLK); #1;
    for (int c = 0; c < 4; c++) begin
      bus.ram_ready = (c == 3);
      @(negedge CLK); #1;
      check("ws_dwait", {31'b0, bus.dwait}, {31'b0, c != 3});
      check("ws_addr", bus.ramaddr, 32'h700);
      @(posedge CLK); #1;
    end
    clear_req();
`ifndef MEMORY_ARBITER_RR_EN
    // data priority over a simultaneous instruction request
    @(posedge CLK); #1;
    base = done_cnt;
    bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h100;
    sb_q.push_back(mk(1'b1, 32'h100, 32'h0, 1'b1, 1'b0));
    sb_q.push_back(mk(1'b0, 32'h80, 32'h0, 1'b1, 1'b0));
    @(posedge CLK); #1;
    check("prio_addr", bus.ramaddr, 32'h100);
    check("prio_iwait", {31'b0, bus.iwait}, 32'd1);
    @(posedge CLK); #1;
    bus.dREN = 1'b0;
    wait_done(base + 2, 10);
    @(posedge CLK); #1;
    clear_req();
`endif
    // contention held continuously
    @(posedge CLK); #1;
    base = done_cnt;
    bus.dWEN = 1'b1; bus.daddr = 32'h500; bus.dstore = 32'h55;
    bus.iREN = 1'b1; bus.iaddr = 32'h600;
    for (int k = 0; k < 10; k++) begin
`ifdef MEMORY_ARBITER_RR_EN
      if (k % 2 == 1) sb_q.push_back(mk(1'b1, 32'h500, 32'h55, 1'b0, 1'b1));
`else
      if (k % 5 != 4) sb_q.push_back(mk(1'b1, 32'h500, 32'h55, 1'b0, 1'b1));
`endif
      else sb_q.push_back(mk(1'b0, 32'h600, 32'h0, 1'b1, 1'b0));
    end
    wait_done(base + 10, 40);
    @(posedge CLK); #1;
    clear_req();
`ifndef MEMORY_ARBITER_RR_EN
    // withdrawal mid-grant leaves the starvation count untouched
    @(posedge CLK); #1;
    base = done_cnt;
    bus.dREN = 1'b1; bus.daddr = 32'h800; bus.iREN = 1'b1; bus.iaddr = 32'h900;
    for (int k = 0; k < 3; k++) sb_q.push_back(mk(1'b1, 32'h800, 32'h0, 1'b1, 1'b0));
    wait_done(base + 3, 20);
    @(posedge CLK); #1;
    bus.ram_ready = 1'b0;
    @(posedge CLK); #1;
    check("wd_pre_strobe", {31'b0, bus.ramREN}, 32'd1);
    bus.dREN = 1'b0;
    @(negedge CLK); #1;
    check("wd_strobe", {31'b0, bus.ramREN}, 32'd0);
    check("wd_dwait", {31'b0, bus.dwait}, 32'd0);
    @(posedge CLK); #1;
    check("wd_idle_addr", bus.ramaddr, 32'd0);
    check("wd_idle_iwait", {31'b0, bus.iwait}, 32'd1);
    bus.dREN = 1'b1; bus.ram_ready = 1'b1;
    sb_q.push_back(mk(1'b1, 32'h800, 32'h0, 1'b1, 1'b0));
    sb_q.push_back(mk(1'b0, 32'h900, 32'h0, 1'b1, 1'b0));
    wait_done(base + 5, 20);
    @(posedge CLK); #1;
    clear_req();
`endif
    repeat (3) @(posedge CLK);
    #1;
    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
